// File: rtl/elastic_pipe_if.sv
// Handshake bundle for elastic_pipe: upstream push, downstream pop, flush and fill level.
// The master side drives stimulus; the slave side is the pipe itself.
interface elastic_pipe_if #(
    parameter int W     = 8,
    parameter int DEPTH = 2
);
    localparam int OCC_W = $clog2(DEPTH + 2);

    logic             flush;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_ready;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/elastic_pipe.sv
// DEPTH-stage valid/ready register pipeline with bubble collapsing, flush and fill count.
// Define ELASTIC_PIPE_SKID_EN to add a one-entry input skid and a registered in_ready.
module elastic_pipe #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    elastic_pipe_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH + 2);

    logic [DEPTH-1:0]        vld_pipe;
    logic [DEPTH-1:0][W-1:0] data_pipe;
    logic [DEPTH-1:0]        adv;
    logic [DEPTH-1:0]        inc;
    logic [OCC_W-1:0]        occ;
    logic                    s0_open;
    logic                    s0_load;
    logic [W-1:0]            s0_data;
    logic                    in_xfer;
    logic                    out_xfer;

    // Advance propagates backward from the output: a stage moves when its
    // successor is empty or moving, so bubbles collapse under an output stall.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = vld_pipe[DEPTH-1] && bus.out_ready && !bus.flush;
        for (int s = DEPTH - 2; s >= 0; s--)
            adv[s] = vld_pipe[s] && (!vld_pipe[s+1] || adv[s+1]);
    end

    always_comb begin
        inc = '0;
        inc[0] = s0_load;
        for (int s = 1; s < DEPTH; s++)
            inc[s] = adv[s-1];
    end

    assign s0_open       = !vld_pipe[0] || adv[0];
    assign out_xfer      = adv[DEPTH-1];
    assign bus.out_valid = vld_pipe[DEPTH-1] && !bus.flush;
    assign bus.out_data  = data_pipe[DEPTH-1];
    assign bus.occupancy = occ;

`ifdef ELASTIC_PIPE_SKID_EN
    logic         skid_vld;
    logic [W-1:0] skid_data;

    // in_ready comes straight off the skid flop; flush is gated internally.
    assign bus.in_ready = !skid_vld;
    assign in_xfer      = bus.in_valid && !skid_vld && !bus.flush;
    assign s0_load      = s0_open && (skid_vld || in_xfer);
    assign s0_data      = skid_vld ? skid_data : bus.in_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_vld  <= 1'b0;
            skid_data <= '0;
        end else if (bus.flush) begin
            skid_vld  <= 1'b0;
        end else if (skid_vld) begin
            if (s0_open) skid_vld <= 1'b0;
        end else if (in_xfer && !s0_open) begin
            skid_vld  <= 1'b1;
            skid_data <= bus.in_data;
        end
    end
`else
    assign bus.in_ready = !bus.flush && s0_open;
    assign in_xfer      = bus.in_valid && bus.in_ready;
    assign s0_load      = in_xfer;
    assign s0_data      = bus.in_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
        end else if (bus.flush) begin
            vld_pipe  <= '0;
        end else begin
            vld_pipe <= inc | (vld_pipe & ~adv);
            if (inc[0]) data_pipe[0] <= s0_data;
            for (int s = 1; s < DEPTH; s++)
                if (inc[s]) data_pipe[s] <= data_pipe[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                     occ <= '0;
        else if (bus.flush)             occ <= '0;
        else if (in_xfer && !out_xfer)  occ <= occ + OCC_W'(1);
        else if (out_xfer && !in_xfer)  occ <= occ - OCC_W'(1);
    end
endmodule

// File: tb/tb_elastic_pipe.sv
// Directed checks of elastic_pipe (W=8, DEPTH=2, default build without skid).
module tb_elastic_pipe;
    localparam int W = 8;
    localparam int D = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    elastic_pipe_if #(.W(W), .DEPTH(D)) bus();
    elastic_pipe #(.W(W), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        #1;
        vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        vecs++; if (bus.occupancy !== 2'd0) begin errs++; $display("FAIL reset_occupancy got %0d want 0", bus.occupancy); end
        vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
        vecs++; if (bus.out_data !== 8'h00) begin errs++; $display("FAIL reset_out_data got %0h want 00", bus.out_data); end
        tick;
    endtask

    task automatic test_stream;
        logic exp_v;
        bus.out_ready = 1'b1;
        for (int w = 0; w < 16 + D + 1; w++) begin
            bus.in_valid = (w < 16);
            bus.in_data  = 8'(w + 1);
            #1;
            exp_v = (w >= D) && (w <= 15 + D);
            vecs++; if (bus.out_valid !== exp_v) begin errs++; $display("FAIL stream_valid w=%0d got %0b want %0b", w, bus.out_valid, exp_v); end
            if (exp_v) begin
                vecs++; if (bus.out_data !== 8'(w - D + 1)) begin errs++; $display("FAIL stream_data w=%0d got %0h want %0h", w, bus.out_data, 8'(w - D + 1)); end
            end
            tick;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_stall;
        logic [7:0] a [3];
        int idx;
        logic acc;
        a[0] = 8'hA0; a[1] = 8'hA1; a[2] = 8'hA2;
        idx = 0;
        bus.out_ready = 1'b0;
        for (int w = 0; w < 5; w++) begin
            bus.in_valid = (idx < 3);
            bus.in_data  = a[(idx < 3) ? idx : 2];
            #1;
            acc = bus.in_valid && bus.in_ready;
            if (w >= 2) begin
                vecs++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL stall_in_ready w=%0d got %0b want 0", w, bus.in_ready); end
                vecs++; if (bus.out_data !== 8'hA0) begin errs++; $display("FAIL stall_out_data w=%0d got %0h want a0", w, bus.out_data); end
            end
            tick;
            if (acc) idx++;
        end
        bus.in_valid = 1'b0;
        #1;
        vecs++; if (bus.occupancy !== 2'd2) begin errs++; $display("FAIL stall_occupancy got %0d want 2", bus.occupancy); end
        vecs++; if (idx !== 2) begin errs++; $display("FAIL stall_accepted got %0d want 2", idx); end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            vecs++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL drain_valid k=%0d got %0b want 1", k, bus.out_valid); end
            vecs++; if (bus.out_data !== a[k]) begin errs++; $display("FAIL drain_data k=%0d got %0h want %0h", k, bus.out_data, a[k]); end
            tick;
        end
        vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL drain_empty got %0b want 0", bus.out_valid); end
        vecs++; if (bus.occupancy !== 2'd0) begin errs++; $display("FAIL drain_occupancy got %0d want 0", bus.occupancy); end
    endtask

    task automatic test_full_both;
        logic [7:0] exp [6];
        exp[0] = 8'hB0; exp[1] = 8'hB1; exp[2] = 8'hC0; exp[3] = 8'hC1; exp[4] = 8'hC2; exp[5] = 8'hC3;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data = 8'hB0; tick;
        bus.in_data = 8'hB1; tick;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in_data = 8'(8'hC0 + k);
            #1;
            vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL both_in_ready k=%0d got %0b want 1", k, bus.in_ready); end
            vecs++; if (bus.out_data !== exp[k]) begin errs++; $display("FAIL both_out_data k=%0d got %0h want %0h", k, bus.out_data, exp[k]); end
            vecs++; if (bus.occupancy !== 2'd2) begin errs++; $display("FAIL both_occupancy k=%0d got %0d want 2", k, bus.occupancy); end
            tick;
        end
        bus.in_valid = 1'b0;
        for (int k = 4; k < 6; k++) begin
            #1;
            vecs++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp[k]) begin errs++; $display("FAIL both_drain k=%0d got %0b/%0h want 1/%0h", k, bus.out_valid, bus.out_data, exp[k]); end
            tick;
        end
        vecs++; if (bus.occupancy !== 2'd0) begin errs++; $display("FAIL both_empty got %0d want 0", bus.occupancy); end
    endtask

    task automatic test_flush;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data = 8'hD0; tick;
        bus.in_data = 8'hD1; tick;
        bus.flush = 1'b1; bus.in_data = 8'hEE;
        #1;
        vecs++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL flush_in_ready got %0b want 0", bus.in_ready); end
        vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL flush_out_valid got %0b want 0", bus.out_valid); end
        tick;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        #1;
        vecs++; if (bus.occupancy !== 2'd0) begin errs++; $display("FAIL flush_occupancy got %0d want 0", bus.occupancy); end
        vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL flush_in_ready_after got %0b want 1", bus.in_ready); end
        for (int k = 0; k < 3; k++) begin
            vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL flush_absent k=%0d got %0b want 0", k, bus.out_valid); end
            tick;
        end
    endtask

    task automatic test_reset_mid;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data = 8'hE0; tick;
        bus.in_data = 8'hE1; tick;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        #1;
        vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL rstmid_out_valid got %0b want 0", bus.out_valid); end
        vecs++; if (bus.occupancy !== 2'd0) begin errs++; $display("FAIL rstmid_occupancy got %0d want 0", bus.occupancy); end
        vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL rstmid_in_ready got %0b want 1", bus.in_ready); end
        vecs++; if (bus.out_data !== 8'h00) begin errs++; $display("FAIL rstmid_out_data got %0h want 00", bus.out_data); end
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'h5A;
        tick;
        bus.in_valid = 1'b0;
        #1;
        vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL push5a_early got %0b want 0", bus.out_valid); end
        tick;
        vecs++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A) begin errs++; $display("FAIL push5a_out got %0b/%0h want 1/5a", bus.out_valid, bus.out_data); end
        tick;
        vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL push5a_alone got %0b want 0", bus.out_valid); end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_stall;
        test_full_both;
        test_flush;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/elastic_pipe.md
ELASTIC_PIPE -- requirements
Module: elastic_pipe

Interface
REQ-001 Parameter: W, default 8, data width in bits (W >= 1).
REQ-002 Parameter: DEPTH, default 2, number of register stages (DEPTH >= 1).
REQ-003 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: flush  input  1  synchronous clear of all held data.
REQ-006 Port: in_valid  input  1  upstream offers in_data.
REQ-007 Port: in_data  input  W  upstream data.
REQ-008 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-009 Port: out_valid  output  1  out_data holds a valid item.
REQ-010 Port: out_data  output  W  oldest held item.
REQ-011 Port: out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 Port: occupancy  output  $clog2(DEPTH+2)  count of valid items held.

Function
REQ-013 Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready; both are evaluated at the rising edge.
REQ-014 Each stage s in 0..DEPTH-1 holds a valid bit and a W-bit data register; the data register loads only on advance (enable semantics), and it never loads while the stage's valid bit is 0 and nothing arrives.
REQ-015 Stage DEPTH-1 drives out_valid/out_data (no skid, REQ-029); a stage advances when it is valid and the next stage is empty or advancing; the last stage advances on transfer out.
REQ-016 Bubbles collapse: a valid stage moves into an empty successor even while the output stalls.
REQ-017 Latency: an item accepted at edge N, with no stall, appears on out_valid after edge N+DEPTH-1 (observable in the cycle following that edge).
REQ-018 Throughput: one transfer per cycle sustained when out_ready is held 1.
REQ-019 Ordering: items leave in acceptance order; no loss, no duplication.
REQ-020 in_ready (no skid) = stage 0 empty or stage 0 advancing; combinational from out_ready is permitted.
REQ-021 Full (occupancy = capacity) with out_ready=0: in_ready=0, all registers hold, and out_data stays stable.
REQ-022 Full with out_ready=1: simultaneous in and out transfers are allowed, and occupancy is unchanged.
REQ-023 occupancy: +1 on transfer in only, -1 on transfer out only, unchanged on both or neither; it never exceeds capacity and never underflows.
REQ-024 flush=1: in_ready=0 that cycle; no transfer in; out_valid is forced to 0 that cycle; at the edge all valid bits clear and occupancy becomes 0.
REQ-025 flush takes priority over every transfer; data registers need not clear.

Reset
REQ-026 rst_n=0 at an edge clears all valid bits and sets occupancy=0; reset has priority over flush and transfers.
REQ-027 Outputs after reset: out_valid=0, occupancy=0, in_ready=1, out_data=0 (data registers reset to 0).
REQ-028 Reset asserted mid-stream discards all held items; no partial transfer is reported.

Configuration
REQ-029 Macro ELASTIC_PIPE_SKID_EN: when defined, a one-entry skid register sits at the input, and in_ready is driven directly by a flop (= skid empty), with no combinational path from out_ready or flush to in_ready.
REQ-030 With ELASTIC_PIPE_SKID_EN: capacity = DEPTH+1; an item that is accepted while stage 0 cannot advance lands in skid, and the skid drains into stage 0 before new input; latency per REQ-017 is unchanged when the skid is empty; flush and reset also clear the skid.
REQ-031 Without ELASTIC_PIPE_SKID_EN: capacity = DEPTH, and no skid logic is present.

Verification
REQ-032 Reset, then idle, with W=8, DEPTH=2 -> out_valid=0, occupancy=0, in_ready=1.
REQ-033 Stream 0x01..0x10, with in_valid=1 and out_ready=1 held -> out_data 0x01..0x10 in order, one per cycle, first one DEPTH-1 cycles after acceptance.
REQ-034 out_ready=0 while pushing 0xA0,0xA1,0xA2 -> occupancy saturates at 2 (3 with skid), in_ready=0, out_data=0xA0 stable; release out_ready -> 0xA0,0xA1(,0xA2) drain in order.
REQ-035 Full, in_valid=1 and out_ready=1 for 4 cycles -> 4 in and 4 out, occupancy constant.
REQ-036 Two items held, flush pulse together with in_valid=1 -> next cycle out_valid=0, occupancy=0, and the flushed-cycle input is absent from the output.
REQ-037 rst_n=0 for one edge with DEPTH items held -> REQ-027 values; a subsequent push of 0x5A emerges alone.
